// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: issues pipelined word reads to the fixed-latency
// program memory and queues returned words for decode in a show-ahead buffer.
module instr_fetch_unit #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        enable_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc_in,
    output logic [31:0] mem_addr_out,
    output logic        mem_read_request_out,
    input  logic [31:0] mem_instr_in,
    input  logic        mem_data_valid_in,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        valid_out,
    input  logic        ready_in
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [SUM_W-1:0] DEPTH_C  = SUM_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

    logic [31:0]      fetch_pc;
    logic [31:0]      resp_pc;
    logic [31:0]      target_pc;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] discard;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [31:0]      fifo_pc    [FIFO_DEPTH];
    logic [31:0]      fifo_instr [FIFO_DEPTH];
    logic [SUM_W-1:0] credits_used;
    logic             head_valid;
    logic             issue;
    logic             ret_live;
    logic             push;
    logic             pop;
    logic             unused_pc_lsbs;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign target_pc      = {redirect_pc_in[31:2], 2'b00};
    assign unused_pc_lsbs = ^redirect_pc_in[1:0];

    // Buffered plus outstanding words never exceed the buffer size, so a push always has room.
    assign credits_used = SUM_W'(count) + SUM_W'(inflight);
    assign head_valid   = (count != '0);
    assign issue        = enable_in && !redirect_in && (credits_used < DEPTH_C);
    assign ret_live     = mem_data_valid_in && (inflight != '0);
    assign push         = ret_live && (discard == '0) && !redirect_in;
    assign pop          = head_valid && ready_in;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            fetch_pc             <= RESET_PC;
            resp_pc              <= RESET_PC;
            mem_addr_out         <= RESET_PC;
            mem_read_request_out <= 1'b0;
            inflight             <= '0;
            discard              <= '0;
        end else if (redirect_in) begin
            // Everything still outstanding belongs to the old stream and must be dropped.
            fetch_pc             <= target_pc;
            resp_pc              <= target_pc;
            mem_read_request_out <= 1'b0;
            inflight             <= inflight - CNT_W'(ret_live);
            discard              <= inflight - CNT_W'(ret_live);
        end else begin
            mem_read_request_out <= issue;
            if (issue) begin
                mem_addr_out <= fetch_pc;
                fetch_pc     <= fetch_pc + 32'd4;
            end
            inflight <= inflight + CNT_W'(issue) - CNT_W'(ret_live);
            if (ret_live && (discard != '0)) begin
                discard <= discard - CNT_W'(1);
            end
            if (push) begin
                resp_pc <= resp_pc + 32'd4;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_pc[i]    <= '0;
                fifo_instr[i] <= '0;
            end
        end else if (redirect_in) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo_pc[wr_ptr]    <= resp_pc;
                fifo_instr[wr_ptr] <= mem_instr_in;
                wr_ptr             <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign valid_out = head_valid;
    assign instr_out = head_valid ? fifo_instr[rd_ptr] : '0;
    assign pc_out    = head_valid ? fifo_pc[rd_ptr] : '0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a 2-cycle memory model plus a queue-based model of
// the decode-visible stream, with directed scenarios followed by random traffic.
module tb_instr_fetch_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk_in;
    logic        rst_n_in;
    logic        enable_in;
    logic        redirect_in;
    logic [31:0] redirect_pc_in;
    logic [31:0] mem_addr_out;
    logic        mem_read_request_out;
    logic [31:0] mem_instr_in;
    logic        mem_data_valid_in;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        valid_out;
    logic        ready_in;

    instr_fetch_unit #(.FIFO_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk_in               (clk_in),
        .rst_n_in             (rst_n_in),
        .enable_in            (enable_in),
        .redirect_in          (redirect_in),
        .redirect_pc_in       (redirect_pc_in),
        .mem_addr_out         (mem_addr_out),
        .mem_read_request_out (mem_read_request_out),
        .mem_instr_in         (mem_instr_in),
        .mem_data_valid_in    (mem_data_valid_in),
        .instr_out            (instr_out),
        .pc_out               (pc_out),
        .valid_out            (valid_out),
        .ready_in             (ready_in)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    typedef struct { bit v; logic [31:0] a; int ep; int rg; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] ins; } word_t;

    int          total = 0;
    int          bad   = 0;
    mreq_t       p1, p2;
    word_t       q[$];
    int          epoch = 0;
    int          rgen  = 0;
    logic [31:0] next_req_pc  = RPC;
    logic [31:0] next_resp_pc = RPC;
    bit          exp_req  = 1'b0;
    logic [31:0] exp_addr = RPC;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: check outputs of the last edge, advance the memory, drive inputs
    // for the next edge and predict what that edge does to the visible stream.
    task automatic step(input bit en, input bit rdy, input bit rd, input logic [31:0] rpc);
        mreq_t cur, resp;
        int    infl;
        @(negedge clk_in);
        check("valid", valid_out, q.size() != 0);
        if (q.size() != 0) begin
            check("pc", pc_out, q[0].pc);
            check("instr", instr_out, q[0].ins);
        end
        check("req", mem_read_request_out, exp_req);
        check("addr", mem_addr_out, exp_addr);

        cur  = '{v: mem_read_request_out, a: mem_addr_out, ep: epoch, rg: rgen};
        resp = p2;
        p2   = p1;
        p1   = cur;
        mem_data_valid_in = resp.v;
        mem_instr_in      = resp.v ? mem_word(resp.a) : 32'hDEAD_BEEF;
        enable_in      = en;
        ready_in       = rdy;
        redirect_in    = rd;
        redirect_pc_in = rpc;

        infl = 0;
        if (resp.v && resp.rg == rgen) infl++;
        if (p2.v && p2.rg == rgen) infl++;
        if (p1.v && p1.rg == rgen) infl++;
        exp_req = en && !rd && (q.size() + infl < DEPTH);
        if (exp_req) begin
            exp_addr    = next_req_pc;
            next_req_pc = next_req_pc + 32'd4;
        end
        if (q.size() != 0 && rdy) void'(q.pop_front());
        if (rd) begin
            epoch++;
            q.delete();
            next_req_pc  = {rpc[31:2], 2'b00};
            next_resp_pc = {rpc[31:2], 2'b00};
        end else if (resp.v && resp.rg == rgen && resp.ep == epoch) begin
            q.push_back('{pc: next_resp_pc, ins: mem_word(next_resp_pc)});
            next_resp_pc = next_resp_pc + 32'd4;
            check("no_overflow", q.size() <= DEPTH, 1);
        end
    endtask

    task automatic redir_check(input logic [31:0] tgt);
        logic [31:0] t;
        t = {tgt[31:2], 2'b00};
        step(1, 1, 1, tgt);
        step(1, 1, 0, 0);
        check("redir_flush", valid_out, 0);
        check("redir_noissue", mem_read_request_out, 0);
        step(1, 1, 0, 0);
        check("redir_req", mem_read_request_out, 1);
        check("redir_addr", mem_addr_out, t);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        check("redir_lat", valid_out, 0);
        step(1, 1, 0, 0);
        check("redir_first_v", valid_out, 1);
        check("redir_first_pc", pc_out, t);
    endtask

    initial begin
        rst_n_in = 1'b0;
        enable_in = 1'b0;
        redirect_in = 1'b0;
        redirect_pc_in = '0;
        ready_in = 1'b0;
        mem_data_valid_in = 1'b0;
        mem_instr_in = '0;
        p1 = '{v: 1'b0, a: '0, ep: 0, rg: 0};
        p2 = '{v: 1'b0, a: '0, ep: 0, rg: 0};

        // Reset state and startup latency.
        step(0, 0, 0, 0);
        check("rst_valid", valid_out, 0);
        check("rst_addr", mem_addr_out, RPC);
        check("rst_pc", pc_out, 0);
        check("rst_instr", instr_out, 0);
        step(1, 1, 0, 0);
        rst_n_in = 1'b1;
        step(1, 1, 0, 0);
        check("first_req", mem_read_request_out, 1);
        check("first_addr", mem_addr_out, RPC);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        check("lat_pre", valid_out, 0);
        step(1, 1, 0, 0);
        check("lat_first_v", valid_out, 1);
        check("lat_first_pc", pc_out, RPC);
        repeat (8) step(1, 1, 0, 0);

        // Decode stalls: credits run out, stream resumes without gaps.
        repeat (10) step(1, 0, 0, 0);
        check("stall_req_off", mem_read_request_out, 0);
        check("stall_valid", valid_out, 1);
        repeat (2) step(1, 1, 0, 0);
        redir_check(32'h0000_0102);

        // Redirect in the middle of a steady stream (return and pop on that edge).
        repeat (6) step(1, 1, 0, 0);
        redir_check(32'h0000_2001);

        // Fetch disabled while decode stalls.
        repeat (4) step(1, 1, 0, 0);
        repeat (8) step(0, 0, 0, 0);
        check("dis_req_off", mem_read_request_out, 0);
        check("dis_valid", valid_out, 1);
        repeat (12) step(1, 1, 0, 0);

        // Asynchronous reset between edges with responses still in the memory pipe.
        repeat (4) step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        #2 rst_n_in = 1'b0;
        #1;
        check("arst_valid", valid_out, 0);
        check("arst_req", mem_read_request_out, 0);
        check("arst_addr", mem_addr_out, RPC);
        check("arst_pc", pc_out, 0);
        check("arst_instr", instr_out, 0);
        #1 rst_n_in = 1'b1;
        rgen++;
        epoch++;
        q.delete();
        next_req_pc  = RPC;
        next_resp_pc = RPC;
        exp_req      = 1'b0;
        exp_addr     = RPC;
        repeat (3) step(0, 1, 0, 0);
        check("stale_dropped", valid_out, 0);
        step(1, 1, 0, 0);
        repeat (3) step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        check("arst_first_v", valid_out, 1);
        check("arst_first_pc", pc_out, RPC);

        // Random traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 4) < 3,
                 $urandom_range(0, 29) == 0, $urandom);
        end
        repeat (10) step(0, 1, 0, 0);
        check("drain_empty", valid_out, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
